audio_dac_tx: RTL and testbench
===============================

// Module: audio_dac_tx
// PURPOSE
//  Audio output path; the transmit-direction counterpart of the MIC3 ADC capture path.
//  Accepts 12-bit samples on a valid/ready handshake and serialises each one over a
//  3-wire SPI frame to a DAC121S101-class DAC (Pmod DA2 style).
//  Sits beside Audio_Capture in Top_Student and runs from the 100 MHz board clock.
//  Upstream logic (tone/playback) presents one sample per clk20k period.
// PARAMETERS
//  CLK_DIV  4      CLOCK cycles per SCLK half-period (4 -> 12.5 MHz SCLK); legal range 2..255
//  PD_MODE  2'b00  DAC power-down bits placed in frame[13:12]; 00 = normal operation
// PORTS
//  CLOCK         in   1   100 MHz system clock; the only clock
//  reset         in   1   synchronous, active-high reset
//  sample_in     in   12  unsigned sample to transmit
//  sample_valid  in   1   sample_in is valid this cycle
//  sample_ready  out  1   holding register empty; transfer occurs when valid && ready
//  dac_sync      out  1   SPI frame select, active low
//  dac_sclk      out  1   SPI clock; idles high
//  dac_din       out  1   SPI data, MSB first; changes on SCLK rise, DAC samples on SCLK fall
//  busy          out  1   high while a frame is in progress (SYNC low or inter-frame gap)
//  frame_done    out  1   one-cycle pulse in the cycle dac_sync returns high
// BEHAVIOUR
//  Reset values: dac_sync=1, dac_sclk=1, dac_din=0, busy=0, frame_done=0, sample_ready=1.
//    Holding register and shift register are cleared.
//  Frame word, 16 bits: {2'b00, PD_MODE, sample[11:0]}, transmitted bit15 first.
//  Holding register: one entry.
//    sample_ready = ~hold_full.
//    Accepting a sample sets hold_full; the FSM loading from it clears hold_full.
//    An accept and a load in the same cycle leave hold_full=1 holding the new sample.
//    A sample can therefore be accepted while a frame is still shifting.
//  FSM:
//    IDLE -> START when hold_full:
//      load shreg from hold; dac_sync<=0; dac_din<=frame[15]; busy<=1; divider<=0.
//    START/SHIFT: divider counts 0..CLK_DIV-1 and toggles dac_sclk on each wrap.
//      On each SCLK rise, shift the next bit onto dac_din.
//      After the 16th falling edge and the following rise -> GAP.
//    GAP: dac_sync<=1 with frame_done pulsed in the same cycle. Hold SYNC high for
//      2*CLK_DIV cycles, then go to START if hold_full, else IDLE (busy<=0).
//  Timing: SYNC is low for exactly 32*CLK_DIV cycles; frame period is 34*CLK_DIV cycles.
//    With CLK_DIV=4 that is 128 cycles SYNC low and 136 cycles per frame.
//    Latency from an accept in IDLE to dac_sync low is 2 cycles (accept -> hold -> START).
//  dac_din remains stable from one SCLK rise through the next fall.
//    The first bit is presented with SYNC falling, CLK_DIV cycles before the first fall.
//  Underflow: when no sample is held, the line idles with SYNC=1, SCLK=1, DIN=0 and no
//    frame is produced. The DAC keeps its last value.
//  Overflow: while hold_full=1, sample_ready=0; upstream must hold its data. Samples are
//    never dropped or overwritten.
//  Reset asserted mid-frame: on the next edge all outputs take their reset values, so SYNC
//    rises and the DAC aborts the frame. The held sample is discarded.
//  sample_in bits are used as-is; no sign conversion (mic-style unsigned 12-bit).
// STRUCTURE
//  Shared package/header (audio_defs.vh): FRAME_BITS=16; state encodings IDLE/START/SHIFT/GAP;
//    SAMPLE_W=12.
//  Sub-module dac_sclk_gen: CLK_DIV divider giving sclk, rise_pulse and fall_pulse.
//    Cleared by reset and by frame start.
//  Top file contains the FSM, holding register, 16-bit shift register and 5-bit bit counter.
// TESTING
//  1 Reset, then valid with sample_in=12'hABC -> one frame; bits captured on SCLK falls
//    = 16'h0ABC; SYNC low 128 cycles; frame_done pulses once.
//  2 PD_MODE=2'b01, sample 12'h000 -> captured word 16'h1000; dac_din=0 after bit12.
//  3 Valid held high with 12'h001, 12'h002, 12'h003 back-to-back -> ready drops after the
//    2nd accept; three frames 136 cycles apart; no sample lost or repeated.
//  4 Reset asserted 40 cycles into a frame -> next cycle SYNC=1, SCLK=1, DIN=0, ready=1.
//    No frame_done; the next sample transmits cleanly.
//  5 One sample, then valid low for 10000 cycles -> a single frame, then SYNC stays high
//    with no SCLK toggles.
//  6 CLK_DIV=2, sample 12'hFFF -> captured word 16'h0FFF; SCLK period 4 cycles; SYNC low
//    64 cycles.

Source files
------------

// File: rtl/audio_dac_tx_pkg.sv
// Shared widths, FSM encoding and frame-word builder for the DAC transmit path.
package audio_dac_tx_pkg;

  localparam int unsigned SAMPLE_W   = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned BIT_CNT_W  = 5;
  localparam int unsigned DIV_W      = 8;
  localparam int unsigned GAP_W      = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Two zero bits, the power-down field, then the sample, MSB first on the wire.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [1:0]          pd,
                                                       input logic [SAMPLE_W-1:0] sample);
    return {2'b00, pd, sample};
  endfunction

endpackage

// File: rtl/audio_dac_tx_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles while enabled, parks high otherwise.
module audio_dac_tx_sclk_gen
  import audio_dac_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             wrap_c;

  assign wrap_c = en && (div == DIV_LAST);
  assign rise_c = wrap_c && !sclk;
  assign fall_c = wrap_c && sclk;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      div  <= '0;
      sclk <= 1'b1;
    end else if (wrap_c) begin
      div  <= '0;
      sclk <= ~sclk;
    end else begin
      div  <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// 12-bit sample to DAC121S101-style 3-wire SPI serialiser with a one-entry
// holding register so the next sample can be accepted while a frame shifts.
module audio_dac_tx
  import audio_dac_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [1:0]  PD_MODE = 2'b00
) (
  input  logic                CLOCK,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                dac_sync,
  output logic                dac_sclk,
  output logic                dac_din,
  output logic                busy,
  output logic                frame_done
);

  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  state_t                state;
  logic [SAMPLE_W-1:0]   hold;
  logic                  hold_full;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_c;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  accept_c;
  logic                  load_c;
  logic                  hold_full_nxt_c;
  logic                  sclk_en_c;
  logic                  rise_c;
  logic                  fall_c;

  // A frame starts from IDLE at once, or back-to-back once the gap has elapsed.
  assign accept_c        = sample_valid && sample_ready;
  assign load_c          = hold_full &&
                           ((state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == GAP_LAST)));
  assign hold_full_nxt_c = accept_c || (hold_full && !load_c);
  assign frame_c         = make_frame(PD_MODE, hold);
  assign sclk_en_c       = (state == ST_START) || (state == ST_SHIFT);

  audio_dac_tx_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (CLOCK),
    .reset  (reset),
    .en     (sclk_en_c),
    .sclk   (dac_sclk),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state        <= ST_IDLE;
      hold         <= '0;
      hold_full    <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      sample_ready <= 1'b1;
      dac_sync     <= 1'b1;
      dac_din      <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      hold_full    <= hold_full_nxt_c;
      sample_ready <= !hold_full_nxt_c;
      if (accept_c) begin
        hold <= sample_in;
      end
      if (load_c) begin
        state    <= ST_START;
        shreg    <= frame_c;
        bit_cnt  <= '0;
        dac_sync <= 1'b0;
        dac_din  <= frame_c[FRAME_BITS-1];
        busy     <= 1'b1;
      end else begin
        case (state)
          ST_START: begin
            if (fall_c) begin
              state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            // New data goes out on every SCLK rise; the 16th rise closes the frame.
            if (rise_c) begin
              if (bit_cnt == LAST_BIT) begin
                state      <= ST_GAP;
                gap_cnt    <= '0;
                dac_sync   <= 1'b1;
                dac_din    <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                dac_din <= shreg[FRAME_BITS-2];
                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx: three instances (default, PD_MODE=01, CLK_DIV=2),
// an SPI line monitor capturing bits on SCLK falls, and an expected-word scoreboard.
module tb_audio_dac_tx;

  localparam int NI = 3;
  localparam int unsigned DIVS [NI] = '{4, 4, 2};
  localparam logic [1:0]  PDS  [NI] = '{2'b00, 2'b01, 2'b00};

  typedef struct {
    int          inst;
    logic [15:0] word;
  } exp_t;

  typedef struct {
    int          inst;
    logic [11:0] sample;
    logic [15:0] word;
  } vec_t;

  logic          clk = 1'b0;
  logic [NI-1:0] rst;
  logic [NI-1:0] valid;
  logic [NI-1:0] ready;
  logic [NI-1:0] sync;
  logic [NI-1:0] sclk;
  logic [NI-1:0] din;
  logic [NI-1:0] busy;
  logic [NI-1:0] fdone;
  logic [11:0]   smp [NI];

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   fall_log[$];

  // Line-monitor state per instance
  logic        prev_sync [NI] = '{1'b1, 1'b1, 1'b1};
  logic        prev_sclk [NI] = '{1'b1, 1'b1, 1'b1};
  logic [15:0] cap [NI];
  int          low_cnt [NI];
  int          nfall [NI];
  int          bad_sp [NI];
  int          last_sclk_fall [NI];
  int          sync_fall_cyc [NI];
  int          frames [NI]    = '{0, 0, 0};
  int          idle_tog [NI]  = '{0, 0, 0};
  int          stray_fd [NI]  = '{0, 0, 0};
  int          n_abort [NI]   = '{0, 0, 0};
  logic        abort_exp [NI] = '{1'b0, 1'b0, 1'b0};
  exp_t        e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    audio_dac_tx #(
      .CLK_DIV (DIVS[g]),
      .PD_MODE (PDS[g])
    ) u_dut (
      .CLOCK        (clk),
      .reset        (rst[g]),
      .sample_in    (smp[g]),
      .sample_valid (valid[g]),
      .sample_ready (ready[g]),
      .dac_sync     (sync[g]),
      .dac_sclk     (sclk[g]),
      .dac_din      (din[g]),
      .busy         (busy[g]),
      .frame_done   (fdone[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor samples on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!sync[i]) begin
        if (prev_sync[i]) begin
          low_cnt[i]       = 0;
          nfall[i]         = 0;
          bad_sp[i]        = 0;
          cap[i]           = '0;
          sync_fall_cyc[i] = cyc;
          fall_log.push_back(cyc);
        end
        low_cnt[i]++;
        if (prev_sclk[i] && !sclk[i]) begin
          cap[i] = {cap[i][14:0], din[i]};
          if (nfall[i] > 0 && (cyc - last_sclk_fall[i]) != 2 * int'(DIVS[i])) bad_sp[i]++;
          last_sclk_fall[i] = cyc;
          nfall[i]++;
        end
        if (fdone[i]) stray_fd[i]++;
      end else if (!prev_sync[i]) begin
        if (abort_exp[i]) begin
          abort_exp[i] = 1'b0;
          if (sb.size() > 0) void'(sb.pop_front());
          n_abort[i]++;
        end else begin
          check("frame_done_pulse", fdone[i], 1);
          check("sclk_fall_count", nfall[i], 16);
          check("sync_low_cycles", low_cnt[i], 32 * DIVS[i]);
          check("sclk_period_bad", bad_sp[i], 0);
          check("scoreboard_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("frame_instance", e.inst, i);
            check("frame_word", cap[i], e.word);
          end
          frames[i]++;
        end
      end else begin
        if (sclk[i] != prev_sclk[i]) idle_tog[i]++;
        if (fdone[i]) stray_fd[i]++;
      end
      prev_sync[i] = sync[i];
      prev_sclk[i] = sclk[i];
    end
  end

  // Called #1 after a posedge; returns the same way, one cycle after the accept edge.
  task automatic send(input int i, input logic [11:0] s, input logic [15:0] w, output int acc);
    int n = 0;
    smp[i]   = s;
    valid[i] = 1'b1;
    while (!ready[i] && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("ready_timeout", n < 2000, 1);
    acc = cyc;
    @(posedge clk);
    sb.push_back('{i, w});
    #1 valid[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int target);
    int n = 0;
    while (frames[i] < target && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check("frame_timeout", frames[i] >= target, 1);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("idle_timeout", busy[i], 0);
  endtask

  initial begin
    vec_t vecs [5];
    int   acc;
    int   idx;
    int   f0;
    int   t0;
    int   n;
    int   d1;
    int   d2;

    vecs[0] = '{0, 12'hABC, 16'h0ABC};
    vecs[1] = '{1, 12'h000, 16'h1000};
    vecs[2] = '{2, 12'hFFF, 16'h0FFF};
    vecs[3] = '{0, 12'h555, 16'h0555};
    vecs[4] = '{1, 12'hFFF, 16'h1FFF};

    rst   = '1;
    valid = '0;
    for (int i = 0; i < NI; i++) smp[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sync",  sync,  3'b111);
    check("reset_sclk",  sclk,  3'b111);
    check("reset_din",   din,   3'b000);
    check("reset_busy",  busy,  3'b000);
    check("reset_done",  fdone, 3'b000);
    check("reset_ready", ready, 3'b111);
    rst = '0;
    @(posedge clk); #1;

    // Single frames from idle on each instance, including latency
    for (int k = 0; k < 5; k++) begin
      idx = vecs[k].inst;
      f0  = frames[idx];
      send(idx, vecs[k].sample, vecs[k].word, acc);
      wait_frames(idx, f0 + 1);
      check("accept_to_sync_latency", sync_fall_cyc[idx] - acc, 2);
      wait_idle(idx);
    end

    // Back-to-back samples with valid held high
    fall_log.delete();
    f0 = frames[0];
    send(0, 12'h001, 16'h0001, acc);
    send(0, 12'h002, 16'h0002, acc);
    check("ready_low_after_2nd", ready[0], 0);
    send(0, 12'h003, 16'h0003, acc);
    wait_frames(0, f0 + 3);
    check("b2b_frame_count", fall_log.size(), 3);
    d1 = (fall_log.size() >= 3) ? fall_log[1] - fall_log[0] : -1;
    d2 = (fall_log.size() >= 3) ? fall_log[2] - fall_log[1] : -1;
    check("frame_period_1", d1, 136);
    check("frame_period_2", d2, 136);
    wait_idle(0);

    // Reset 40 cycles into a frame
    send(0, 12'h5A5, 16'h05A5, acc);
    n = 0;
    while (sync[0] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("sync_fall_timeout", sync[0], 0);
    repeat (40) @(posedge clk);
    #1;
    check("busy_mid_frame", busy[0], 1);
    abort_exp[0] = 1'b1;
    rst[0]       = 1'b1;
    @(posedge clk); #1;
    check("abort_sync",  sync[0],  1);
    check("abort_sclk",  sclk[0],  1);
    check("abort_din",   din[0],   0);
    check("abort_ready", ready[0], 1);
    check("abort_done",  fdone[0], 0);
    check("abort_busy",  busy[0],  0);
    rst[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_seen", n_abort[0], 1);
    check("abort_sb_empty", sb.size(), 0);
    f0 = frames[0];
    send(0, 12'h123, 16'h0123, acc);
    wait_frames(0, f0 + 1);
    wait_idle(0);

    // One sample followed by a long underflow
    f0 = frames[0];
    t0 = idle_tog[0];
    send(0, 12'h7E1, 16'h07E1, acc);
    repeat (10000) @(posedge clk);
    #1;
    check("underflow_frames", frames[0] - f0, 1);
    check("underflow_sclk_toggles", idle_tog[0] - t0, 0);
    check("underflow_sync", sync[0], 1);
    check("underflow_sclk", sclk[0], 1);
    check("underflow_din", din[0], 0);
    check("underflow_busy", busy[0], 0);

    check("stray_frame_done", stray_fd[0] + stray_fd[1] + stray_fd[2], 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
